// File: rtl/palette_pkg.sv
// Shared types, default fire palette and the colour-cycling index rotation
// used by the palette lookup arbiter.
package palette_pkg;

  localparam int PAL_IDX_W   = 4;
  localparam int RGB_W       = 24;
  localparam int PAL_ENTRIES = 16;

  typedef logic [RGB_W-1:0]     rgb_t;
  typedef logic [PAL_IDX_W-1:0] pal_idx_t;

  // Entry 0 is the transparent colour; 1..15 form the animated fire gradient.
  localparam rgb_t PAL_DEFAULT [0:PAL_ENTRIES-1] = '{
    24'h000000, 24'hf6cd47, 24'hec8039, 24'hed5d1a,
    24'hf03c13, 24'hd03e23, 24'hf20f03, 24'hac2417,
    24'hc80b05, 24'h980604, 24'h760304, 24'h590203,
    24'h3f0102, 24'h270001, 24'h150000, 24'h030000
  };

  function automatic pal_idx_t pal_rotate(input pal_idx_t idx, input pal_idx_t offset);
    logic [4:0] sum;
    sum = 5'd0;
    if (idx == 4'd0) begin
      pal_rotate = 4'd0;
    end else begin
      sum = {1'b0, idx} - 5'd1 + {1'b0, offset};
      if (sum >= 5'd15) begin
        sum = sum - 5'd15;
      end else begin
        sum = sum;
      end
      pal_rotate = sum[3:0] + 4'd1;
    end
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last granted
// requester and only moves when a transfer is actually accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant
);

  logic last_q;
  logic last_d;

  // Prefer requester 1 only when it is alone or requester 0 won last time.
  always_comb begin
    grant  = req[1] & (~req[0] | ~last_q);
    last_d = last_q;
    if (accept) begin
      last_d = grant;
    end else begin
      last_d = last_q;
    end
  end

  // Pointer register, reset as if requester 1 was granted last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shares a 16x24 palette between the map and sprite renderers through a
// round-robin arbiter and a 2-stage lookup pipeline with colour cycling.
module palette_lookup_arbiter
  import palette_pkg::*;
#(
  parameter int TAG_W    = 4,
  parameter int ANIM_DIV = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_frame_tick,
  input  logic             i_anim_en,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [3:0]       i_req0_idx,
  input  logic [TAG_W-1:0] i_req0_tag,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [3:0]       i_req1_idx,
  input  logic [TAG_W-1:0] i_req1_tag,
  input  logic             i_pal_we,
  input  logic [3:0]       i_pal_waddr,
  input  logic [23:0]      i_pal_wdata,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [23:0]      o_rsp_rgb,
  output logic             o_rsp_transp,
  output logic             o_rsp_src,
  output logic [TAG_W-1:0] o_rsp_tag
);

  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ANIM_DIV - 1);
  localparam pal_idx_t OFFSET_MAX = 4'd14;

  rgb_t             pal_q [PAL_ENTRIES];
  rgb_t             pal_d [PAL_ENTRIES];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  pal_idx_t         offset_q, offset_d;

  logic             a_valid_q, a_valid_d;
  logic             a_src_q, a_src_d;
  logic             a_transp_q, a_transp_d;
  pal_idx_t         a_eff_q, a_eff_d;
  logic [TAG_W-1:0] a_tag_q, a_tag_d;

  logic             b_valid_q, b_valid_d;
  logic             b_src_q, b_src_d;
  logic             b_transp_q, b_transp_d;
  rgb_t             b_rgb_q, b_rgb_d;
  logic [TAG_W-1:0] b_tag_q, b_tag_d;

  logic             adv_s;
  logic             grant_s;
  logic             accept_s;
  pal_idx_t         req_idx_s;

  assign adv_s        = ~b_valid_q | i_rsp_ready;
  assign o_req0_ready = adv_s & ~i_rst & ~grant_s;
  assign o_req1_ready = adv_s & ~i_rst & grant_s;
  assign accept_s     = (i_req0_valid & o_req0_ready) | (i_req1_valid & o_req1_ready);

  rr_arb2 u_arb (
    .clk    (i_clk),
    .rst    (i_rst),
    .req    ({i_req1_valid, i_req0_valid}),
    .accept (accept_s),
    .grant  (grant_s)
  );

  assign o_rsp_valid  = b_valid_q;
  assign o_rsp_rgb    = b_rgb_q;
  assign o_rsp_transp = b_transp_q;
  assign o_rsp_src    = b_src_q;
  assign o_rsp_tag    = b_tag_q;

  // Next-state for palette, animation and both pipeline stages.
  always_comb begin
    pal_d      = pal_q;
    cnt_d      = cnt_q;
    offset_d   = offset_q;
    a_valid_d  = a_valid_q;
    a_src_d    = a_src_q;
    a_transp_d = a_transp_q;
    a_eff_d    = a_eff_q;
    a_tag_d    = a_tag_q;
    b_valid_d  = b_valid_q;
    b_src_d    = b_src_q;
    b_transp_d = b_transp_q;
    b_rgb_d    = b_rgb_q;
    b_tag_d    = b_tag_q;
    req_idx_s  = grant_s ? i_req1_idx : i_req0_idx;

    if (i_pal_we && (i_pal_waddr != 4'd0)) begin
      pal_d[i_pal_waddr] = i_pal_wdata;
    end else begin
      pal_d = pal_q;
    end

    if (i_frame_tick && i_anim_en) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d    = '0;
        offset_d = (offset_q == OFFSET_MAX) ? 4'd0 : offset_q + 4'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q;
    end

    // Stage B reads the pre-write palette, so a same-cycle write is not seen.
    if (adv_s) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) begin
        b_src_d    = a_src_q;
        b_transp_d = a_transp_q;
        b_rgb_d    = pal_q[a_eff_q];
        b_tag_d    = a_tag_q;
      end else begin
        b_rgb_d = b_rgb_q;
      end
      a_valid_d = accept_s;
      if (accept_s) begin
        a_src_d    = grant_s;
        a_tag_d    = grant_s ? i_req1_tag : i_req0_tag;
        a_transp_d = (req_idx_s == 4'd0);
        a_eff_d    = pal_rotate(req_idx_s, offset_q);
      end else begin
        a_eff_d = a_eff_q;
      end
    end else begin
      b_valid_d = b_valid_q;
    end
  end

  // State registers; reset drops in-flight requests and reloads the palette.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < PAL_ENTRIES; i++) begin
        pal_q[i] <= PAL_DEFAULT[i];
      end
      cnt_q      <= '0;
      offset_q   <= 4'd0;
      a_valid_q  <= 1'b0;
      a_src_q    <= 1'b0;
      a_transp_q <= 1'b0;
      a_eff_q    <= 4'd0;
      a_tag_q    <= '0;
      b_valid_q  <= 1'b0;
      b_src_q    <= 1'b0;
      b_transp_q <= 1'b0;
      b_rgb_q    <= 24'h000000;
      b_tag_q    <= '0;
    end else begin
      pal_q      <= pal_d;
      cnt_q      <= cnt_d;
      offset_q   <= offset_d;
      a_valid_q  <= a_valid_d;
      a_src_q    <= a_src_d;
      a_transp_q <= a_transp_d;
      a_eff_q    <= a_eff_d;
      a_tag_q    <= a_tag_d;
      b_valid_q  <= b_valid_d;
      b_src_q    <= b_src_d;
      b_transp_q <= b_transp_d;
      b_rgb_q    <= b_rgb_d;
      b_tag_q    <= b_tag_d;
    end
  end

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Directed bench for palette_lookup_arbiter: arbitration, latency, rotation,
// backpressure, palette writes and reset behaviour against hand-computed values.
module tb_palette_lookup_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        anim_en = 1'b0;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [3:0]  req0_idx = 4'd0;
  logic [3:0]  req0_tag = 4'd0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [3:0]  req1_idx = 4'd0;
  logic [3:0]  req1_tag = 4'd0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_waddr = 4'd0;
  logic [23:0] pal_wdata = 24'h000000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [23:0] rsp_rgb;
  logic        rsp_transp;
  logic        rsp_src;
  logic [3:0]  rsp_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  palette_lookup_arbiter #(.TAG_W(4), .ANIM_DIV(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_frame_tick(frame_tick), .i_anim_en(anim_en),
    .i_req0_valid(req0_valid), .o_req0_ready(req0_ready), .i_req0_idx(req0_idx), .i_req0_tag(req0_tag),
    .i_req1_valid(req1_valid), .o_req1_ready(req1_ready), .i_req1_idx(req1_idx), .i_req1_tag(req1_tag),
    .i_pal_we(pal_we), .i_pal_waddr(pal_waddr), .i_pal_wdata(pal_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rgb(rsp_rgb),
    .o_rsp_transp(rsp_transp), .o_rsp_src(rsp_src), .o_rsp_tag(rsp_tag)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
  endtask

  // Single request; optional palette write lands on the stage-B load edge.
  task automatic lookup(input logic src, input logic [3:0] idx, input logic [3:0] tag,
                        input logic [23:0] exp_rgb, input string name,
                        input logic we, input logic [3:0] waddr, input logic [23:0] wdata);
    @(negedge clk);
    if (src) begin
      req1_valid = 1'b1; req1_idx = idx; req1_tag = tag;
    end else begin
      req0_valid = 1'b1; req0_idx = idx; req0_tag = tag;
    end
    #1 check_eq({name, "_rdy"}, src ? req1_ready : req0_ready, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    pal_we = we; pal_waddr = waddr; pal_wdata = wdata;
    @(negedge clk);
    pal_we = 1'b0;
    #1;
    check_eq({name, "_rgb"}, rsp_rgb, exp_rgb);
    check_eq({name, "_vld_src_tr_tag"}, {rsp_valid, rsp_src, rsp_transp, rsp_tag},
             {1'b1, src, (idx == 4'd0), tag});
  endtask

  logic [23:0] t4_rgb [4];

  initial begin
    t4_rgb = '{24'hed5d1a, 24'hf03c13, 24'hd03e23, 24'hf20f03};

    // Reset state
    @(negedge clk); #1;
    check_eq("rst_outputs", {rsp_valid, rsp_src, rsp_transp, rsp_tag, rsp_rgb}, 32'd0);
    check_eq("rst_readies", {req0_ready, req1_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: single map request, latency 2
    lookup(1'b0, 4'd1, 4'd3, 24'hf6cd47, "t1", 1'b0, 4'd0, 24'h0);

    // 2: both valid, grants alternate starting with req0
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_idx = 4'd2; req0_tag = 4'd1;
    req1_valid = 1'b1; req1_idx = 4'd15; req1_tag = 4'd2;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      #1;
      if (k < 6) check_eq("t2_grant", {req1_ready, req0_ready}, (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k >= 2) begin
        check_eq("t2_rgb", rsp_rgb, ((k - 2) % 2 == 0) ? 24'hec8039 : 24'h030000);
        check_eq("t2_vld_src", {rsp_valid, rsp_src}, {1'b1, ((k - 2) % 2 == 1)});
      end
    end

    // 3: rotation with ANIM_DIV=2
    do_reset();
    anim_en = 1'b1;
    ticks(1);
    lookup(1'b0, 4'd1, 4'd4, 24'hf6cd47, "t3_div", 1'b0, 4'd0, 24'h0);
    ticks(1);
    lookup(1'b0, 4'd1, 4'd5, 24'hec8039, "t3_off1_i1", 1'b0, 4'd0, 24'h0);
    lookup(1'b1, 4'd15, 4'd6, 24'hf6cd47, "t3_off1_i15", 1'b0, 4'd0, 24'h0);
    lookup(1'b0, 4'd0, 4'd7, 24'h000000, "t3_off1_i0", 1'b0, 4'd0, 24'h0);
    anim_en = 1'b0;
    ticks(4);
    lookup(1'b0, 4'd1, 4'd8, 24'hec8039, "t3_frozen", 1'b0, 4'd0, 24'h0);
    anim_en = 1'b1;
    ticks(26);
    lookup(1'b0, 4'd1, 4'd9, 24'h030000, "t3_off14", 1'b0, 4'd0, 24'h0);
    ticks(2);
    lookup(1'b0, 4'd1, 4'd10, 24'hf6cd47, "t3_wrap", 1'b0, 4'd0, 24'h0);
    anim_en = 1'b0;

    // 4: backpressure with a stream of sprite requests
    do_reset();
    begin
      int i = 0;
      int r = 0;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        rsp_ready  = !(c >= 2 && c < 7);
        req1_valid = (i < 4);
        req1_idx   = 4'(i + 3);
        req1_tag   = 4'(i + 1);
        #1;
        if (c >= 2 && c < 7) begin
          check_eq("t4_stall_rdy", req1_ready, 32'd0);
          check_eq("t4_stall_rsp", {rsp_valid, rsp_tag, rsp_rgb}, {1'b1, 4'd1, 24'hed5d1a});
        end
        if (rsp_valid && rsp_ready) begin
          if (r < 4) begin
            check_eq("t4_rsp_rgb", rsp_rgb, t4_rgb[r]);
            check_eq("t4_rsp_src_tag", {rsp_src, rsp_tag}, {1'b1, 4'(r + 1)});
          end
          r++;
        end
        if (req1_valid && req1_ready) i++;
      end
      req1_valid = 1'b0;
      rsp_ready  = 1'b1;
      check_eq("t4_n_req", i, 32'd4);
      check_eq("t4_n_rsp", r, 32'd4);
    end

    // 5: palette writes
    do_reset();
    lookup(1'b0, 4'd1, 4'd1, 24'hf6cd47, "t5_same_cyc", 1'b1, 4'd1, 24'h123456);
    lookup(1'b0, 4'd1, 4'd2, 24'h123456, "t5_next", 1'b0, 4'd0, 24'h0);
    lookup(1'b1, 4'd0, 4'd3, 24'h000000, "t5_addr0", 1'b1, 4'd0, 24'hffffff);
    lookup(1'b1, 4'd0, 4'd4, 24'h000000, "t5_addr0_after", 1'b0, 4'd0, 24'h0);

    // 6: reset with the pipeline full and stalled
    lookup(1'b0, 4'd2, 4'd1, 24'hec8039, "t6_pre", 1'b1, 4'd2, 24'habcdef);
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_idx = 4'd2; req0_tag = 4'd5;
    @(negedge clk);
    req0_idx = 4'd3; req0_tag = 4'd6;
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    check_eq("t6_full_rsp", {rsp_valid, rsp_tag, rsp_rgb}, {1'b1, 4'd5, 24'habcdef});
    rst = 1'b1;
    #1;
    check_eq("t6_rst_outputs", {rsp_valid, rsp_src, rsp_transp, rsp_tag, rsp_rgb}, 32'd0);
    check_eq("t6_rst_readies", {req0_ready, req1_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check_eq("t6_dropped", rsp_valid, 32'd0);
    end
    @(negedge clk);
    req0_valid = 1'b1; req0_idx = 4'd2; req0_tag = 4'd7;
    req1_valid = 1'b1; req1_idx = 4'd4; req1_tag = 4'd8;
    #1 check_eq("t6_first_grant", {req1_ready, req0_ready}, 32'd1);
    @(negedge clk);
    req0_valid = 1'b0;
    #1 check_eq("t6_second_grant", {req1_ready, req0_ready}, 32'd2);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    check_eq("t6_rsp0_rgb", rsp_rgb, 24'hec8039);
    check_eq("t6_rsp0_meta", {rsp_valid, rsp_src, rsp_tag}, {1'b1, 1'b0, 4'd7});
    @(negedge clk); #1;
    check_eq("t6_rsp1_rgb", rsp_rgb, 24'hf03c13);
    check_eq("t6_rsp1_meta", {rsp_valid, rsp_src, rsp_tag}, {1'b1, 1'b1, 4'd8});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
